// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and state type for the HI/LO multiply/divide unit
package mips_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  localparam int MD_ITERATIONS = 32;
  localparam int MD_LATENCY    = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request, MTHI/MTLO and HI/LO result bundle of the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU engine holding the architectural HI/LO registers
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  md
);

  localparam int CW = $clog2(MD_ITERATIONS);

  md_state_t          state;
  logic [1:0]         op_q;
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   ma_q;
  logic [WIDTH-1:0]   mb_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  // Signed ops are MULT/DIV, i.e. op[0] clear
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign a_neg = ~md.op[0] & md.a[WIDTH-1];
  assign b_neg = ~md.op[0] & md.b[WIDTH-1];
  assign abs_a = a_neg ? neg_w(md.a) : md.a;
  assign abs_b = b_neg ? neg_w(md.b) : md.b;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma_q : {WIDTH{1'b0}})};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mb_q};
  assign div_ge    = ~div_diff[WIDTH];

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               div_zero;
  assign prod_fix = (sa_q ^ sb_q) ? neg_2w(acc) : acc;
  assign quo_fix  = (sa_q ^ sb_q) ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign rem_fix  = sa_q ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  assign div_zero = (mb_q == {WIDTH{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      ma_q   <= '0;
      mb_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start) begin
            op_q  <= md.op;
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            ma_q  <= abs_a;
            mb_q  <= abs_b;
            acc   <= {{WIDTH{1'b0}}, (md.op[1] ? abs_a : abs_b)};
            cnt   <= '0;
            state <= CALC;
          end else begin
            if (md.hi_we) hi_q <= md.wdata;
            if (md.lo_we) lo_q <= md.wdata;
          end
        end
        CALC: begin
          if (op_q[1])
            acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(MD_ITERATIONS - 1)) state <= SIGN;
        end
        SIGN: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            // Divide by zero reports all-ones quotient and the untouched dividend
            hi_q <= sa_q ? neg_w(ma_q) : ma_q;
            lo_q <= {WIDTH{1'b1}};
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy = (state != IDLE);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for the HI/LO multiply/divide unit
module tb_muldiv_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // kind[0]: re-assert start at cycle inj, kind[1]: hi_we at cycle inj, kind[2]: hi_we alongside start
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input logic [2:0] kind);
    int lat;
    bit busy_ok;
    bit hold_ok;
    lat = -1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    @(negedge clk);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    if (kind[2]) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.a = $urandom();
    bus.b = $urandom();
    for (int n = 1; n <= 40; n++) begin
      if (n == inj && kind[0]) begin
        bus.start = 1'b1;
        bus.op = MD_OP_MULTU;
        bus.a = 32'h0000_1111;
        bus.b = 32'h0000_2222;
      end
      if (n == inj && kind[1]) begin
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
    end
    chk("latency", 64'(lat), 64'(MD_LATENCY));
    chk("busy_while_running", 64'(busy_ok), 64'd1);
    chk("hilo_hold_while_busy", 64'(hold_ok), 64'd1);
    chk("busy_low_at_done", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    chk("done_single_cycle", 64'(bus.done), 64'd0);
  endtask

  task automatic check_result(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    chk({name, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({name, "_lo"}, 64'(bus.lo), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;

    vecs[0]  = '{MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MD_OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{MD_OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[3]  = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{MD_OP_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6]  = '{MD_OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{MD_OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[8]  = '{MD_OP_MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800};
    vecs[9]  = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[10] = '{MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[11] = '{MD_OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 3'b000);
      check_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end

    // MTLO alone, then MTHI+MTLO together
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    check_result("mtlo", m_hi, 32'h0000_0055);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check_result("mthi_mtlo", 32'h0000_0077, 32'h0000_0077);

    run_op(MD_OP_DIVU, 32'd7, 32'd2, 5, 3'b001);
    check_result("restart_ignored", 32'd1, 32'd3);
    run_op(MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 10, 3'b010);
    check_result("mthi_busy_dropped", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(MD_OP_DIVU, 32'd100, 32'd7, 0, 3'b100);
    check_result("start_beats_mthi", 32'd2, 32'd14);

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    bus.op = MD_OP_MULT;
    bus.a = 32'h0000_1234;
    bus.b = 32'h0000_5678;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    chk("midreset_hi", 64'(bus.hi), 64'd0);
    chk("midreset_lo", 64'(bus.lo), 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
    end
    chk("no_done_after_reset", 64'(bus.done), 64'd0);
    chk("idle_after_reset", 64'(bus.busy), 64'd0);
    run_op(MD_OP_MULT, 32'h0000_1234, 32'h0000_5678, 0, 3'b000);
    check_result("after_reset", 32'h0000_0000, 32'h0626_0060);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
